// File: rtl/gamepad_pmod_tx.sv
// gamepad_pmod_tx: serializes two 12-button controllers onto the Gamepad Pmod wires
// (data/clk/latch); every output is registered from the next-state values.
module gamepad_pmod_tx #(
  parameter int CLK_DIV = 4,
  parameter int FRAME_GAP = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [11:0] buttons0,
  input  logic [11:0] buttons1,
  output logic        pmod_data,
  output logic        pmod_clk,
  output logic        pmod_latch,
  output logic        busy,
  output logic        frame_done
);
  localparam int M1 = (2 * CLK_DIV > FRAME_GAP) ? 2 * CLK_DIV : FRAME_GAP;
  localparam int MAXC = (M1 > 24) ? M1 : 24;
  localparam int W = $clog2(MAXC + 1);
  localparam logic [W-1:0] BIT_END = W'(2 * CLK_DIV - 1);
  localparam logic [W-1:0] HALF = W'(CLK_DIV);
  localparam logic [W-1:0] LAT_END = W'(CLK_DIV - 1);
  localparam logic [W-1:0] GAP_END = W'(FRAME_GAP - 1);
  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, GAP} state_t;
  state_t state, state_n;
  logic [W-1:0] cnt, cnt_n;
  logic [4:0] idx, idx_n;
  logic [23:0] sr, sr_n;
  logic start;
  always_comb begin
    state_n = state;
    cnt_n = cnt + 1'b1;
    idx_n = idx;
    sr_n = sr;
    start = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        start = enable;
      end
      SHIFT:
        if (cnt == BIT_END) begin
          cnt_n = '0;
          state_n = (idx == 5'd0) ? LATCH : SHIFT;
          idx_n = (idx == 5'd0) ? idx : idx - 5'd1;
          sr_n = {sr[22:0], 1'b0};
        end
      LATCH:
        if (cnt == LAT_END) begin
          cnt_n = '0;
          state_n = GAP;
        end
      default:
        if (cnt == GAP_END) begin
          cnt_n = '0;
          state_n = IDLE;
          start = enable;
        end
    endcase
    // a snapshot in IDLE or at the end of the gap enters SHIFT at bit 23
    if (start) begin
      state_n = SHIFT;
      idx_n = 5'd23;
      sr_n = {buttons1, buttons0};
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sr <= '0;
      pmod_data <= 1'b0;
      pmod_clk <= 1'b0;
      pmod_latch <= 1'b0;
      busy <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      sr <= sr_n;
      pmod_data <= (state_n == SHIFT) && sr_n[23];
      pmod_clk <= (state_n == SHIFT) && (cnt_n >= HALF);
      pmod_latch <= state_n == LATCH;
      busy <= (state_n == SHIFT) || (state_n == LATCH);
      frame_done <= (state_n == GAP) && (state != GAP);
    end
endmodule

// File: tb/tb_gamepad_pmod_tx.sv
// tb_gamepad_pmod_tx: randomized frames checked by a wire-level receiver model
// and per-frame waveform accounting.
module tb_gamepad_pmod_tx;
  localparam int C = 4;
  localparam int G = 64;
  logic clk = 0, reset = 1, enable = 0;
  logic [11:0] buttons0 = 0, buttons1 = 0;
  logic pmod_data, pmod_clk, pmod_latch, busy, frame_done;
  int total = 0, bad = 0;
  int cyc = 0, edges = 0, latches = 0, lat_hi = 0, busy_cyc = 0, fds = 0, last_fd = 0, viol = 0;
  logic [23:0] rx_sr = 0, rx_word = 0;
  logic ppclk = 0, plat = 0;

  gamepad_pmod_tx #(.CLK_DIV(C), .FRAME_GAP(G)) dut (
    .clk(clk), .reset(reset), .enable(enable), .buttons0(buttons0), .buttons1(buttons1),
    .pmod_data(pmod_data), .pmod_clk(pmod_clk), .pmod_latch(pmod_latch),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // receiver model: shift on pmod_clk rise, capture on pmod_latch rise
  always @(negedge clk) begin
    cyc++;
    if (pmod_clk && !ppclk) begin
      rx_sr = {rx_sr[22:0], pmod_data};
      edges++;
    end
    if (pmod_latch && !plat) begin
      rx_word = rx_sr;
      latches++;
    end
    if (pmod_latch) lat_hi++;
    if (busy) busy_cyc++;
    if (frame_done) begin
      fds++;
      last_fd = cyc;
    end
    if (pmod_latch && pmod_clk) viol++;
    ppclk = pmod_clk;
    plat = pmod_latch;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_fd(output bit ok);
    int f0 = fds;
    ok = 0;
    for (int i = 0; i < 700 && !ok; i++) begin
      step();
      ok = fds != f0;
    end
  endtask

  task automatic wait_busy(output bit ok);
    ok = 0;
    for (int i = 0; i < 700 && !ok; i++) begin
      step();
      ok = busy;
    end
  endtask

  task automatic test_reset();
    int n;
    bit seen;
    reset = 1;
    enable = 1;
    buttons0 = 12'($urandom);
    buttons1 = 12'($urandom) | 12'h800;
    for (int i = 0; i < 8; i++) begin
      step();
      total++;
      if ({pmod_data, pmod_clk, pmod_latch, busy, frame_done} !== 5'b0) begin
        bad++;
        $display("FAIL reset_outputs: got %b want 00000", {pmod_data, pmod_clk, pmod_latch, busy, frame_done});
      end
    end
    reset = 0;
    n = 0;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      step();
      n++;
      if (n == 1) begin
        total++;
        if ({busy, pmod_clk, pmod_data} !== {2'b10, buttons1[11]}) begin
          bad++;
          $display("FAIL first_cycle: busy/clk/data got %b want %b", {busy, pmod_clk, pmod_data}, {2'b10, buttons1[11]});
        end
      end
      seen = pmod_clk;
    end
    total++;
    if (!seen || n != C + 1) begin
      bad++;
      $display("FAIL first_rise: got %0d cycles want %0d", n, C + 1);
    end
    total++;
    if (pmod_data !== buttons1[11]) begin
      bad++;
      $display("FAIL first_bit: got %b want %b", pmod_data, buttons1[11]);
    end
  endtask

  task automatic test_first_frame();
    bit ok;
    logic [23:0] exp = {buttons1, buttons0};
    wait_fd(ok);
    total++;
    if (!ok || rx_word !== exp) begin
      bad++;
      $display("FAIL first_frame: got %h want %h (fd=%0d)", rx_word, exp, ok);
    end
  endtask

  task automatic test_loopback();
    bit ok;
    buttons0 = 12'h801;
    buttons1 = 12'h000;
    wait_fd(ok);
    wait_fd(ok);
    total++;
    if (!ok || rx_word !== 24'h000801) begin
      bad++;
      $display("FAIL loopback: got %h want 000801", rx_word);
    end
  endtask

  task automatic test_waveform();
    bit ok;
    int c0, e0, l0, h0, b0;
    c0 = last_fd; e0 = edges; l0 = latches; h0 = lat_hi; b0 = busy_cyc;
    wait_fd(ok);
    total++;
    if (!ok || last_fd - c0 != 48 * C + C + G) begin
      bad++;
      $display("FAIL period: got %0d want %0d", last_fd - c0, 48 * C + C + G);
    end
    total++;
    if (edges - e0 != 24 || latches - l0 != 1 || lat_hi - h0 != C) begin
      bad++;
      $display("FAIL edges: clk %0d latch %0d/%0d want 24 1/%0d", edges - e0, latches - l0, lat_hi - h0, C);
    end
    total++;
    if (busy_cyc - b0 != 49 * C) begin
      bad++;
      $display("FAIL busy_len: got %0d want %0d", busy_cyc - b0, 49 * C);
    end
  endtask

  task automatic test_mid_change();
    bit ok;
    buttons0 = 12'hFFF;
    buttons1 = 12'h000;
    wait_busy(ok);
    repeat (5 * 2 * C + 2) step();
    buttons0 = 12'h000;
    wait_fd(ok);
    total++;
    if (!ok || rx_word !== 24'h000FFF) begin
      bad++;
      $display("FAIL mid_change: got %h want 000fff", rx_word);
    end
    wait_fd(ok);
    total++;
    if (!ok || rx_word !== 24'h000000) begin
      bad++;
      $display("FAIL mid_next: got %h want 000000", rx_word);
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [23:0] exp;
    for (int k = 0; k < 6; k++) begin
      wait_busy(ok);
      exp = {buttons1, buttons0};
      buttons0 = 12'($urandom);
      buttons1 = 12'($urandom);
      wait_fd(ok);
      total++;
      if (!ok || rx_word !== exp) begin
        bad++;
        $display("FAIL random_%0d: got %h want %h", k, rx_word, exp);
      end
    end
  endtask

  task automatic test_enable_drop();
    bit ok, busy_seen;
    int e0;
    logic [23:0] exp;
    wait_busy(ok);
    exp = {buttons1, buttons0};
    repeat (20) step();
    enable = 0;
    wait_fd(ok);
    total++;
    if (!ok || rx_word !== exp) begin
      bad++;
      $display("FAIL drop_frame: got %h want %h", rx_word, exp);
    end
    e0 = edges;
    busy_seen = 0;
    repeat (G + 300) begin
      step();
      busy_seen |= busy;
    end
    total++;
    if (edges != e0 || busy_seen) begin
      bad++;
      $display("FAIL drop_idle: extra edges %0d busy %b want 0 0", edges - e0, busy_seen);
    end
  endtask

  task automatic test_reset_latch();
    bit ok, hit;
    int f0, l0;
    logic [23:0] held;
    enable = 1;
    buttons0 = 12'($urandom);
    buttons1 = 12'($urandom);
    wait_fd(ok);
    hit = 0;
    for (int i = 0; i < 700 && !hit; i++) begin
      step();
      hit = pmod_latch;
    end
    @(negedge clk);
    reset = 1;
    #1;
    total++;
    if (!hit || pmod_latch !== 1'b0) begin
      bad++;
      $display("FAIL async_latch: latch %b reached %b want 0 1", pmod_latch, hit);
    end
    held = rx_word;
    f0 = fds;
    l0 = latches;
    repeat (3) step();
    enable = 0;
    reset = 0;
    repeat (300) step();
    total++;
    if (fds != f0 || latches != l0 || rx_word !== held) begin
      bad++;
      $display("FAIL reset_latch: fd %0d latch %0d rx %h want 0 0 %h", fds - f0, latches - l0, rx_word, held);
    end
  endtask

  task automatic test_exclusive();
    total++;
    if (viol != 0) begin
      bad++;
      $display("FAIL clk_latch_overlap: got %0d cycles want 0", viol);
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_loopback();
    test_waveform();
    test_mid_change();
    test_random();
    test_enable_drop();
    test_reset_latch();
    test_exclusive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
